// File: rtl/uart_pkg.sv
// Shared UART constants and the pointer-width helper used by the RX FIFO.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int RX_FIFO_DEPTH_DEF = 16;

    // Smallest width w with 2**w >= value; constant-evaluable for parameters.
    function automatic int uart_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage: synchronous write, synchronous registered read.
// The array itself is never reset; only the read register is.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF,
    parameter int AW    = uart_clog2(RX_FIFO_DEPTH_DEF)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads; a same-address write
    // in the same clock returns the old entry, which is what a full FIFO needs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: one write per RX_DONE rising edge,
// sticky overflow on drops. Optional DROP_CNT via UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = RX_FIFO_DEPTH_DEF,
    localparam int AW    = uart_clog2(DEPTH)
) (
    input  logic                   SYS_CLK,
    input  logic                   RST_N,
    input  logic [UART_DATA_W-1:0] RX_D,
    input  logic                   RX_DONE,
    input  logic                   RD_EN,
    input  logic                   OVF_CLR,
    output logic [UART_DATA_W-1:0] RD_DATA,
    output logic                   RD_VALID,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic [AW:0]            COUNT,
    output logic                   OVERFLOW
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]             DROP_CNT
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          rx_done_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q;
    logic          rd_valid_q;
    logic          ovf_q, ovf_d;
    logic          wr_stb, rd_acc, wr_acc, drop;

    always_comb begin
        wr_stb   = RX_DONE & ~rx_done_q;
        rd_acc   = RD_EN & ~empty_q;
        // A read in the same clock frees a slot, so a full FIFO still accepts.
        wr_acc   = wr_stb & (~full_q | rd_acc);
        drop     = wr_stb & full_q & ~rd_acc;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end
    end

    // rx_done_q resets high so a level already present at release is not a write.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_done_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_done_q  <= RX_DONE;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == FULL_CNT);
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (OVF_CLR) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (SYS_CLK),
        .rst_ni  (RST_N),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (RX_D),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (RD_DATA)
    );

    assign RD_VALID = rd_valid_q;
    assign EMPTY    = empty_q;
    assign FULL     = full_q;
    assign COUNT    = count_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based model checked every clock plus directed literals.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_d;
    logic       rx_done;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .SYS_CLK  (clk),
        .RST_N    (rst_n),
        .RX_D     (rx_d),
        .RX_DONE  (rx_done),
        .RD_EN    (rd_en),
        .OVF_CLR  (ovf_clr),
        .RD_DATA  (rd_data),
        .RD_VALID (rd_valid),
        .EMPTY    (empty),
        .FULL     (full),
        .COUNT    (count),
        .OVERFLOW (overflow)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .DROP_CNT (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the observable registers.
    logic [7:0] exp_q[$];
    logic       m_prev;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovf;
    int         m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_prev  = 1'b1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
            m_drop  = 0;
        end else begin
            logic stb, rd, dropped;
            stb     = rx_done && !m_prev;
            m_prev  = rx_done;
            rd      = rd_en && (exp_q.size() > 0);
            dropped = 1'b0;
            m_valid = rd;
            if (rd) m_data = exp_q.pop_front();
            if (stb) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(rx_d);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (ovf_clr) m_drop = dropped ? 1 : 0;
            else if (dropped && m_drop < 255) m_drop++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count", int'(count), exp_q.size());
            chk("m_empty", int'(empty), int'(exp_q.size() == 0));
            chk("m_full", int'(full), int'(exp_q.size() == DEPTH));
            chk("m_valid", int'(rd_valid), int'(m_valid));
            chk("m_data", int'(rd_data), int'(m_data));
            chk("m_ovf", int'(overflow), int'(m_ovf));
`ifdef UART_RX_FIFO_DROP_CNT_EN
            chk("m_drop_cnt", int'(drop_cnt), m_drop);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        tick();
        rx_d    = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_valid", int'(rd_valid), 1);
        chk("pop_data", int'(rd_data), int'(exp));
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_d    = 8'h00;
        rx_done = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Three bytes in, three out.
        put(8'h55); put(8'hA3); put(8'h0F);
        chk("three_count", int'(count), 3);
        pop(8'h55); pop(8'hA3); pop(8'h0F);
        tick();
        chk("three_empty", int'(empty), 1);

        // Read while empty is ignored and RD_DATA holds.
        tick(); rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("empty_rd_valid", int'(rd_valid), 0);
        chk("empty_rd_hold", int'(rd_data), 8'h0F);

        // Long RX_DONE level writes once.
        tick();
        rx_d = 8'h7E; rx_done = 1'b1;
        repeat (200) tick();
        rx_done = 1'b0;
        tick();
        chk("long_count", int'(count), 1);
        pop(8'h7E);
        tick();
        chk("long_empty", int'(empty), 1);

        // 17 writes into 16 slots.
        for (int i = 0; i <= 16; i++) put(8'(i));
        tick();
        chk("ovf_full", int'(full), 1);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("ovf_drop_cnt", int'(drop_cnt), 1);
`endif
        for (int i = 0; i < 16; i++) pop(8'(i));
        tick(); ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // Full with write and read in the same clock.
        for (int i = 0; i < 16; i++) put(8'(8'h20 + i));
        tick();
        rx_d = 8'h99; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        chk("fullrw_valid", int'(rd_valid), 1);
        chk("fullrw_data", int'(rd_data), 8'h20);
        chk("fullrw_count", int'(count), 16);
        chk("fullrw_ovf", int'(overflow), 0);

        // Drop coinciding with OVF_CLR leaves overflow set.
        tick();
        rx_d = 8'hEE; rx_done = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_done = 1'b0; ovf_clr = 1'b0;
        chk("clr_drop_ovf", int'(overflow), 1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("clr_drop_cnt", int'(drop_cnt), 1);
`endif
        for (int i = 1; i < 16; i++) pop(8'(8'h20 + i));
        pop(8'h99);
        tick(); ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Empty with write and read in the same clock.
        tick();
        rx_d = 8'h42; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        chk("emptyrw_valid", int'(rd_valid), 0);
        chk("emptyrw_count", int'(count), 1);
        pop(8'h42);

        // Reset mid-operation with RX_DONE held high.
        for (int i = 0; i < 5; i++) put(8'(8'hC0 + i));
        tick();
        chk("pre_rst_count", int'(count), 5);
        rx_d = 8'hBB; rx_done = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_ovf", int'(overflow), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_nowrite", int'(count), 0);
        rx_done = 1'b0;
        tick();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("post_rst_write", int'(count), 1);
        pop(8'hBB);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 4..256.
REQ-002 Parameter AW, default log2(DEPTH), pointer width; SHALL be derived, not overridden.
REQ-003 SYS_CLK  in  1  single clock for all logic.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 RX_D  in  8  received byte from the UART receiver.
REQ-006 RX_DONE  in  1  byte-complete level from the receiver, high for one or more clocks per byte.
REQ-007 RD_EN  in  1  pop request from the consumer.
REQ-008 OVF_CLR  in  1  clears the sticky overflow flag.
REQ-009 RD_DATA  out  8  popped byte, registered.
REQ-010 RD_VALID  out  1  one-clock pulse qualifying RD_DATA.
REQ-011 EMPTY  out  1  FIFO holds zero entries.
REQ-012 FULL  out  1  FIFO holds DEPTH entries.
REQ-013 COUNT  out  AW+1  current entry count, 0..DEPTH.
REQ-014 OVERFLOW  out  1  sticky; a byte was dropped.

Function
REQ-015 Write strobe SHALL be the rising edge of RX_DONE: wr_stb = RX_DONE & ~rx_done_d, rx_done_d registered RX_DONE; exactly one write per RX_DONE high period, regardless of its length.
REQ-016 On wr_stb with FIFO not full, RX_D SHALL be stored at wr_ptr in the same clock; wr_ptr increments modulo DEPTH.
REQ-017 On RD_EN with FIFO not empty, the entry at rd_ptr SHALL appear on RD_DATA with RD_VALID=1 the next clock (latency 1); rd_ptr increments modulo DEPTH.
REQ-018 RD_EN while EMPTY SHALL be ignored: no RD_VALID, RD_DATA holds its last value, pointers unchanged.
REQ-019 When RD_VALID=0, RD_DATA SHALL hold its previous value.
REQ-020 Simultaneous wr_stb and accepted read SHALL both complete; COUNT unchanged.
REQ-021 wr_stb while FULL with accepted RD_EN in the same clock SHALL be accepted (read frees the slot); no overflow.
REQ-022 wr_stb while FULL without RD_EN SHALL drop the byte, leave storage and pointers unchanged, and set OVERFLOW on the next clock.
REQ-023 wr_stb while EMPTY with RD_EN in the same clock: write accepted, read ignored; the byte becomes readable from the next clock.
REQ-024 OVERFLOW SHALL stay 1 until OVF_CLR; if OVF_CLR and a new drop occur in the same clock, OVERFLOW SHALL be 1.
REQ-025 COUNT, EMPTY and FULL SHALL be registered and consistent on every clock; EMPTY = (COUNT==0), FULL = (COUNT==DEPTH).
REQ-026 Pointers SHALL be AW bits wide; full/empty disambiguation SHALL use COUNT.

Reset
REQ-027 On RST_N low: pointers=0, COUNT=0, EMPTY=1, FULL=0, RD_DATA=0, RD_VALID=0, OVERFLOW=0, asynchronously.
REQ-028 rx_done_d SHALL reset to 1, so an RX_DONE already high at reset release creates no write.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.

Configuration
REQ-030 Macro UART_RX_FIFO_DROP_CNT_EN defined: adds output DROP_CNT (8 bits), incremented per dropped byte, saturating at 255, cleared to 0 by reset or OVF_CLR; OVF_CLR with a simultaneous drop gives 1.
REQ-031 Macro undefined: DROP_CNT port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8, RX_FIFO_DEPTH_DEF=16 and the log2 pointer-width function.
REQ-033 Storage SHALL be a sub-module uart_fifo_ram: DEPTH x 8, synchronous write, synchronous read, no reset on the array.

Verification
REQ-034 Write 3 bytes 0x55, 0xA3, 0x0F via RX_DONE pulses, then 3 RD_EN -> RD_DATA 0x55, 0xA3, 0x0F, each one clock after RD_EN; EMPTY=1 at end.
REQ-035 Hold RX_DONE high 200 clocks with RX_D=0x7E -> COUNT=1, exactly one entry 0x7E.
REQ-036 Write 17 bytes 0x00..0x10 with DEPTH=16 and no reads -> FULL=1, OVERFLOW=1, DROP_CNT=1 if enabled; reads return 0x00..0x0F.
REQ-037 FULL with wr_stb (0x99) and RD_EN in the same clock -> no overflow, COUNT=16, 0x99 read last.
REQ-038 EMPTY with RD_EN and wr_stb (0x42) in the same clock -> no RD_VALID that clock; next RD_EN returns 0x42.
REQ-039 Reset pulse with COUNT=5 and RX_DONE high -> COUNT=0, EMPTY=1, OVERFLOW=0, no write after release until RX_DONE falls and rises again.
